// File: rtl/mem_cycle_timer.sv
// PDP-8/I memory cycle timer: sequences TS1-TS4 and TP1-TP4 on 50 ns ticks.
// Outputs are registered decodes of the state register, one tick behind it.
module mem_cycle_timer #(
    parameter int TS1_LEN = 7,
    parameter int TS2_LEN = 8,
    parameter int TS3_LEN = 7,
    parameter int TS4_LEN = 8,
    parameter int TP_W    = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic start,
    input  logic halt,
    input  logic pause,
    output logic mem_start_n,
    output logic ts1,
    output logic ts2,
    output logic ts3,
    output logic ts4,
    output logic tp1,
    output logic tp2,
    output logic tp3,
    output logic tp4,
    output logic busy,
    output logic cycle_done
);

    typedef enum logic [2:0] {
        IDLE,
        S_TS1,
        S_TS2,
        S_TS3,
        S_TS4
    } state_t;

    localparam logic [4:0] END1 = 5'(TS1_LEN - 1);
    localparam logic [4:0] END2 = 5'(TS2_LEN - 1);
    localparam logic [4:0] END3 = 5'(TS3_LEN - 1);
    localparam logic [4:0] END4 = 5'(TS4_LEN - 1);
    localparam logic [4:0] TPS1 = 5'(TS1_LEN - TP_W);
    localparam logic [4:0] TPS2 = 5'(TS2_LEN - TP_W);
    localparam logic [4:0] TPS3 = 5'(TS3_LEN - TP_W);
    localparam logic [4:0] TPS4 = 5'(TS4_LEN - TP_W);
    localparam logic [4:0] HOLD = 5'(TS3_LEN - TP_W - 1);

    state_t     state_q;
    state_t     state_d;
    logic [4:0] cnt_q;
    logic [4:0] cnt_d;
    logic       start_q;
    logic       start_edge;
    logic       go_on;

    assign start_edge = start & ~start_q;
    assign go_on      = run & ~halt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 5'd1;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_edge || go_on) begin
                    state_d = S_TS1;
                end
            end
            S_TS1: begin
                if (cnt_q == END1) begin
                    state_d = S_TS2;
                    cnt_d   = '0;
                end
            end
            S_TS2: begin
                if (cnt_q == END2) begin
                    state_d = S_TS3;
                    cnt_d   = '0;
                end
            end
            S_TS3: begin
                if (cnt_q == END3) begin
                    state_d = S_TS4;
                    cnt_d   = '0;
                end else if (pause && cnt_q == HOLD) begin
                    // I/O pause parks TS3 just before TP3 opens
                    cnt_d = cnt_q;
                end
            end
            S_TS4: begin
                if (cnt_q == END4) begin
                    state_d = go_on ? S_TS1 : IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start;
        end
    end

    logic s1;
    logic s2;
    logic s3;
    logic s4;

    assign s1 = (state_q == S_TS1);
    assign s2 = (state_q == S_TS2);
    assign s3 = (state_q == S_TS3);
    assign s4 = (state_q == S_TS4);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_start_n <= 1'b1;
            ts1         <= 1'b0;
            ts2         <= 1'b0;
            ts3         <= 1'b0;
            ts4         <= 1'b0;
            tp1         <= 1'b0;
            tp2         <= 1'b0;
            tp3         <= 1'b0;
            tp4         <= 1'b0;
            busy        <= 1'b0;
            cycle_done  <= 1'b0;
        end else begin
            mem_start_n <= ~(s1 && cnt_q == 5'd0);
            ts1         <= s1;
            ts2         <= s2;
            ts3         <= s3;
            ts4         <= s4;
            tp1         <= s1 && cnt_q >= TPS1;
            tp2         <= s2 && cnt_q >= TPS2;
            tp3         <= s3 && cnt_q >= TPS3;
            tp4         <= s4 && cnt_q >= TPS4;
            busy        <= s1 | s2 | s3 | s4;
            cycle_done  <= s4 && cnt_q == END4;
        end
    end

endmodule

// File: tb/tb_mem_cycle_timer.sv
// Scoreboard bench for mem_cycle_timer: per-tick expected output vectors
// are queued from the tick map and compared as the DUT produces them.
module tb_mem_cycle_timer;

    logic clk = 1'b0;
    logic reset;
    logic run;
    logic start;
    logic halt;
    logic pause;
    logic mem_start_n;
    logic ts1, ts2, ts3, ts4;
    logic tp1, tp2, tp3, tp4;
    logic busy;
    logic cycle_done;

    int checks = 0;
    int errors = 0;
    logic [10:0] q[$];
    logic [10:0] exp_v;
    logic [10:0] obs;

    localparam logic [10:0] IDLE_V = 11'b100_0000_0000;

    mem_cycle_timer dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .start      (start),
        .halt       (halt),
        .pause      (pause),
        .mem_start_n(mem_start_n),
        .ts1        (ts1),
        .ts2        (ts2),
        .ts3        (ts3),
        .ts4        (ts4),
        .tp1        (tp1),
        .tp2        (tp2),
        .tp3        (tp3),
        .tp4        (tp4),
        .busy       (busy),
        .cycle_done (cycle_done)
    );

    always #25 clk = ~clk;

    assign obs = {mem_start_n, ts1, ts2, ts3, ts4,
                  tp1, tp2, tp3, tp4, busy, cycle_done};

    // Expected vector for tick t of a cycle stretched by p pause ticks
    function automatic logic [10:0] exp_cyc(input int t, input int p);
        logic [10:0] v;
        v     = '0;
        v[10] = (t != 1);
        v[9]  = (t >= 1 && t <= 7);
        v[8]  = (t >= 8 && t <= 15);
        v[7]  = (t >= 16 && t <= 22 + p);
        v[6]  = (t >= 23 + p && t <= 30 + p);
        v[5]  = (t >= 6 && t <= 7);
        v[4]  = (t >= 14 && t <= 15);
        v[3]  = (t >= 21 + p && t <= 22 + p);
        v[2]  = (t >= 29 + p && t <= 30 + p);
        v[1]  = (t >= 1 && t <= 30 + p);
        v[0]  = (t == 30 + p);
        return v;
    endfunction

    task automatic push_cyc(input int p);
        for (int t = 1; t <= 30 + p; t++) q.push_back(exp_cyc(t, p));
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) q.push_back(IDLE_V);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b1; start = 1'b1;
        halt = 1'b0; pause = 1'b0;
        push_idle(5);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 2) begin
                reset = 1'b0; run = 1'b0; start = 1'b0;
            end
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL reset: queue empty at %0d", i);
            end else begin
                exp_v = q.pop_front();
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL reset i=%0d got %b want %b", i, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_single();
        start = 1'b1;
        push_idle(1); push_cyc(0); push_idle(2);
        for (int i = 0; i < 33; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL single: queue empty at %0d", i);
            end else begin
                exp_v = q.pop_front();
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL single tick=%0d got %b want %b", i, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_run();
        run = 1'b1;
        push_idle(1); push_cyc(0); push_cyc(0); push_cyc(0); push_idle(2);
        for (int i = 0; i < 93; i++) begin
            tick();
            if (i == 65) run = 1'b0;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL run: queue empty at %0d", i);
            end else begin
                exp_v = q.pop_front();
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL run tick=%0d got %b want %b", i, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_halt();
        run = 1'b1;
        push_idle(1); push_cyc(0); push_cyc(0); push_idle(4);
        for (int i = 0; i < 65; i++) begin
            tick();
            if (i == 40) halt = 1'b1;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL halt: queue empty at %0d", i);
            end else begin
                exp_v = q.pop_front();
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL halt tick=%0d got %b want %b", i, obs, exp_v);
                end
            end
        end
        run = 1'b0; halt = 1'b0;
    endtask

    task automatic test_pause();
        start = 1'b1;
        push_idle(1); push_cyc(5); push_idle(2);
        for (int i = 0; i < 38; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            if (i == 19) pause = 1'b1;
            if (i == 24) pause = 1'b0;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL pause: queue empty at %0d", i);
            end else begin
                exp_v = q.pop_front();
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL pause tick=%0d got %b want %b", i, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_held_start();
        start = 1'b1;
        push_idle(1); push_cyc(0); push_idle(72);
        for (int i = 0; i < 103; i++) begin
            tick();
            if (i == 99) start = 1'b0;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL held: queue empty at %0d", i);
            end else begin
                exp_v = q.pop_front();
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL held tick=%0d got %b want %b", i, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        push_idle(1);
        for (int t = 1; t <= 18; t++) q.push_back(exp_cyc(t, 0));
        push_idle(2); push_idle(3);
        push_idle(1); push_cyc(0); push_idle(1);
        for (int i = 0; i < 56; i++) begin
            tick();
            if (i == 0) start = 1'b0;
            if (i == 18) reset = 1'b1;
            if (i == 20) reset = 1'b0;
            if (i == 23) start = 1'b1;
            if (i == 24) start = 1'b0;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL rstmid: queue empty at %0d", i);
            end else begin
                exp_v = q.pop_front();
                if (obs !== exp_v) begin
                    errors++;
                    $display("FAIL rstmid i=%0d got %b want %b", i, obs, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_run();
        test_halt();
        test_pause();
        test_held_start();
        test_reset_mid();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d entries want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
